rsa_stream_adapter: RTL and testbench

//  Byte-stream front/back end for the 256-bit RSA core. Assembles N, E (once per key)
//  and successive 32-byte ciphertext blocks A from an 8-bit valid/ready RX stream.

---
 rtl/rsa_stream_adapter.sv | 184 ++++++++++++++++++
 tb/tb_rsa_stream_adapter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_stream_adapter.sv
// rsa_stream_adapter
//   Byte-stream front/back end for a 256-bit RSA core. The modulus N and the
//   exponent E are assembled from the RX byte stream once per key. After that,
//   each 32-byte ciphertext block A is assembled and presented to the core as
//   {A,E,N}. The core result is then collected, and its low OUT_BYTES bytes are
//   sent MSB first on the TX byte stream.
//
// Ports
//   i_clk, i_rst              clock (rising edge), asynchronous active-high reset
//   i_rx_data/i_rx_valid      RX byte stream in; accepted when valid & o_rx_ready
//   o_rx_ready
//   i_key_reload              reload request, honoured only between blocks
//   o_tx_data/o_tx_valid      TX byte stream out; consumed when valid & i_tx_ready
//   i_tx_ready
//   o_src_val/i_src_rdy       operand handshake towards the core
//   o_a, o_e, o_n             operands towards the core
//   i_result_val/o_result_rdy result handshake from the core
//   i_a_pow_e                 core result
//   o_busy                    low only while idle in LOAD_A with no bytes taken
module rsa_stream_adapter #(
    parameter int DATA_W    = 256,
    parameter int KEY_BYTES = 32,
    parameter int OUT_BYTES = 31
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    input  logic              i_key_reload,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_src_val,
    input  logic              i_src_rdy,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_e,
    output logic [DATA_W-1:0] o_n,
    input  logic              i_result_val,
    output logic              o_result_rdy,
    input  logic [DATA_W-1:0] i_a_pow_e,
    output logic              o_busy
);

    localparam int SH_W  = 8 * OUT_BYTES;
    localparam int CNT_W = $clog2(KEY_BYTES);
    localparam int TXC_W = $clog2(OUT_BYTES + 1);

    typedef enum logic [2:0] {
        LOAD_N   = 3'd0,
        LOAD_E   = 3'd1,
        LOAD_A   = 3'd2,
        SEND     = 3'd3,
        WAIT_RES = 3'd4,
        TX       = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TXC_W-1:0]    tx_cnt_q, tx_cnt_d;
    logic [DATA_W-1:0]   n_q, n_d, e_q, e_d, a_q, a_d;
    logic [SH_W-1:0]     shift_q, shift_d;
    logic                rx_ready_q, rx_ready_d;
    logic                src_val_q, src_val_d;
    logic                result_rdy_q, result_rdy_d;
    logic                tx_valid_q, tx_valid_d;
    logic                busy_q, busy_d;

    logic                reload_hit;
    logic                rx_fire;
    logic                tx_fire;
    logic                cnt_last;
    logic                tx_last;

    // The reload request outranks a byte offered in the same cycle. Ready is
    // masked combinationally so that the byte is not consumed.
    assign reload_hit = i_key_reload && (state_q == LOAD_A) && (cnt_q == '0);
    assign o_rx_ready = rx_ready_q && !reload_hit;
    assign rx_fire    = i_rx_valid && o_rx_ready;
    assign tx_fire    = tx_valid_q && i_tx_ready;
    assign cnt_last   = (cnt_q == CNT_W'(KEY_BYTES - 1));
    assign tx_last    = (tx_cnt_q == TXC_W'(OUT_BYTES - 1));

    assign o_tx_data    = shift_q[SH_W-1 -: 8];
    assign o_tx_valid   = tx_valid_q;
    assign o_src_val    = src_val_q;
    assign o_result_rdy = result_rdy_q;
    assign o_busy       = busy_q;
    assign o_a          = a_q;
    assign o_e          = e_q;
    assign o_n          = n_q;

    // Result bits above the transmitted window are intentionally dropped.
    generate
        if (SH_W < DATA_W) begin : g_drop_hi
            logic unused_result_hi;
            assign unused_result_hi = ^i_a_pow_e[DATA_W-1:SH_W];
        end
    endgenerate

    // State and datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= LOAD_N;
            cnt_q        <= '0;
            tx_cnt_q     <= '0;
            n_q          <= '0;
            e_q          <= '0;
            a_q          <= '0;
            shift_q      <= '0;
            rx_ready_q   <= 1'b0;
            src_val_q    <= 1'b0;
            result_rdy_q <= 1'b0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tx_cnt_q     <= tx_cnt_d;
            n_q          <= n_d;
            e_q          <= e_d;
            a_q          <= a_d;
            shift_q      <= shift_d;
            rx_ready_q   <= rx_ready_d;
            src_val_q    <= src_val_d;
            result_rdy_q <= result_rdy_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD_N:   if (rx_fire && cnt_last) state_d = LOAD_E;
            LOAD_E:   if (rx_fire && cnt_last) state_d = LOAD_A;
            LOAD_A: begin
                if (reload_hit)                state_d = LOAD_N;
                else if (rx_fire && cnt_last)  state_d = SEND;
            end
            SEND:     if (i_src_rdy)           state_d = WAIT_RES;
            WAIT_RES: if (i_result_val)        state_d = TX;
            TX:       if (tx_fire && tx_last)  state_d = LOAD_A;
            default:                           state_d = LOAD_N;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        cnt_d    = cnt_q;
        tx_cnt_d = tx_cnt_q;
        n_d      = n_q;
        e_d      = e_q;
        a_d      = a_q;
        shift_d  = shift_q;

        // Byte assembly: the first byte received ends up in the MSB.
        if (rx_fire) begin
            cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
            case (state_q)
                LOAD_N:  n_d = {n_q[DATA_W-9:0], i_rx_data};
                LOAD_E:  e_d = {e_q[DATA_W-9:0], i_rx_data};
                LOAD_A:  a_d = {a_q[DATA_W-9:0], i_rx_data};
                default: ;
            endcase
        end

        if (state_q == WAIT_RES && i_result_val) begin
            shift_d  = i_a_pow_e[SH_W-1:0];
            tx_cnt_d = '0;
        end else if (tx_fire) begin
            shift_d  = {shift_q[SH_W-9:0], 8'h00};
            tx_cnt_d = tx_last ? '0 : tx_cnt_q + 1'b1;
        end

        rx_ready_d   = (state_d == LOAD_N) || (state_d == LOAD_E) || (state_d == LOAD_A);
        src_val_d    = (state_d == SEND);
        tx_valid_d   = (state_d == TX);
        result_rdy_d = (state_q == WAIT_RES) && i_result_val;
        busy_d       = !((state_d == LOAD_A) && (cnt_d == '0));
    end

endmodule

// File: tb/tb_rsa_stream_adapter.sv
// Directed bench for rsa_stream_adapter. It includes a small core stand-in
// that is driven by hand.
module tb_rsa_stream_adapter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   rx_data = '0;
    logic         rx_valid = 1'b0;
    logic         rx_ready;
    logic         key_reload = 1'b0;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    logic         src_val;
    logic         src_rdy = 1'b0;
    logic [255:0] a, e, n;
    logic         result_val = 1'b0;
    logic         result_rdy;
    logic [255:0] a_pow_e = '0;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    rsa_stream_adapter dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_rx_ready   (rx_ready),
        .i_key_reload (key_reload),
        .o_tx_data    (tx_data),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready),
        .o_src_val    (src_val),
        .i_src_rdy    (src_rdy),
        .o_a          (a),
        .o_e          (e),
        .o_n          (n),
        .i_result_val (result_val),
        .o_result_rdy (result_rdy),
        .i_a_pow_e    (a_pow_e),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %s: observed %h", tag, obs);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("rx_ready_timeout", 256'(t), 256'(0));
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [255:0] w, input int first, input int count);
        for (int i = first; i < first + count; i++) send_byte(w[255-8*i -: 8]);
    endtask

    // Give the operands to the core, then return the result r as a core would.
    task automatic core_handshake(input logic [255:0] r);
        @(negedge clk);
        check("src_val_held", src_val, 1);
        src_rdy = 1'b1;
        @(posedge clk);
        #1 src_rdy = 1'b0;
        check("src_val_drop", src_val, 0);
        @(negedge clk);
        @(negedge clk);
        result_val = 1'b1;
        a_pow_e    = r;
        @(posedge clk);
        #1 result_val = 1'b0;
        check("result_rdy_pulse", result_rdy, 1);
        check("tx_valid_first", tx_valid, 1);
        @(posedge clk);
        #1 check("result_rdy_single", result_rdy, 0);
    endtask

    // Receive up to nbytes of the low 31 bytes of r, MSB first.
    task automatic recv_block(input logic [255:0] r, input bit toggle, input int nbytes);
        int got = 0;
        int t = 0;
        while (got < nbytes && t < 300) begin
            @(negedge clk);
            tx_ready = toggle ? ~tx_ready : 1'b1;
            if (tx_valid && tx_ready) begin
                check($sformatf("tx_byte_%0d", got), tx_data, r[247-8*got -: 8]);
                got++;
            end
            t++;
        end
        if (t >= 300) check("tx_timeout", 256'(got), 256'(nbytes));
        if (nbytes == 31) begin
            @(negedge clk);
            tx_ready = 1'b0;
            check("tx_valid_after_31", tx_valid, 0);
            check("rx_ready_load_a", rx_ready, 1);
            check("busy_idle", busy, 0);
        end
    endtask

    logic [255:0] key_n, key_e, key_n2, key_e2, key_n3, res1, res2, blk_a;

    initial begin
        key_n  = 256'hCA3586E7EA485F3B0A222A4C79F7DD12E85388ECCDEE4035940D774C029CF831;
        key_e  = 256'h10001;
        key_n2 = 256'hF00DFACE_12345678_9ABCDEF0_0BADBEEF_DEADC0DE_55AA55AA_0F1E2D3C_4B5A6978;
        key_e2 = 256'h3;
        key_n3 = 256'h0102030405060708_1112131415161718_2122232425262728_3132333435363738;
        res1[255:248] = 8'hAB;
        for (int k = 0; k < 31; k++) res1[247-8*k -: 8] = 8'h11 + 8'(k);
        res2[255:248] = 8'hFF;
        for (int k = 0; k < 31; k++) res2[247-8*k -: 8] = 8'(7*k + 3);

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1);
        check("rst_rx_ready", rx_ready, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_src_val", src_val, 0);
        check("rst_n", n, 0);
        rst = 1'b0;
        #1 check("rx_ready_before_clk", rx_ready, 0);
        @(posedge clk);
        #1 check("rx_ready_after_clk", rx_ready, 1);

        // 1: key and first block
        send_bytes(key_n, 0, 32);
        send_bytes(key_e, 0, 32);
        blk_a = 256'h2;
        send_bytes(blk_a, 0, 32);
        check("send_src_val", src_val, 1);
        check("send_rx_ready", rx_ready, 0);
        check("send_a", a, 256'h2);
        check("send_e", e, 256'h10001);
        check("send_n", n, key_n);
        // 2: result return and plain TX
        core_handshake(res1);
        check("tx_first_byte", tx_data, 8'h11);
        recv_block(res1, 1'b0, 31);

        // 3 and 4: second block without reload, with TX ready toggling
        blk_a = 256'h3;
        send_bytes(blk_a, 0, 32);
        check("blk2_a", a, 256'h3);
        check("blk2_e", e, key_e);
        check("blk2_n", n, key_n);
        core_handshake(res2);
        recv_block(res2, 1'b1, 31);

        // 5a: reload together with a byte at LOAD_A count 0
        @(negedge clk);
        key_reload = 1'b1;
        rx_valid   = 1'b1;
        rx_data    = 8'h55;
        #1 check("reload_rx_ready", rx_ready, 0);
        @(posedge clk);
        #1 begin key_reload = 1'b0; rx_valid = 1'b0; end
        @(negedge clk);
        check("reload_busy", busy, 1);
        check("reload_rx_ready_n", rx_ready, 1);
        send_bytes(key_n2, 0, 32);
        check("reload_n", n, key_n2);
        send_bytes(key_e2, 0, 32);
        // 5b: reload during A byte 5 is ignored
        blk_a = 256'h0123456789ABCDEF_FEDCBA9876543210_A5A5A5A55A5A5A5A_00FF00FF00FF00FF;
        send_bytes(blk_a, 0, 5);
        @(negedge clk);
        key_reload = 1'b1;
        @(posedge clk);
        #1 key_reload = 1'b0;
        send_bytes(blk_a, 5, 27);
        check("ign_src_val", src_val, 1);
        check("ign_a", a, blk_a);
        check("ign_e", e, key_e2);
        check("ign_n", n, key_n2);
        core_handshake(res1);
        recv_block(res1, 1'b0, 31);

        // 6: asynchronous reset in the middle of TX
        blk_a = 256'h5;
        send_bytes(blk_a, 0, 32);
        core_handshake(res2);
        recv_block(res2, 1'b0, 10);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_tx_valid", tx_valid, 0);
        check("arst_tx_data", tx_data, 0);
        check("arst_rx_ready", rx_ready, 0);
        check("arst_busy", busy, 1);
        check("arst_result_rdy", result_rdy, 0);
        check("arst_src_val", src_val, 0);
        check("arst_operands", {a | e | n}, 0);
        tx_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        send_bytes(key_n3, 0, 32);
        check("post_rst_n", n, key_n3);
        check("post_rst_e", e, 0);
        check("post_rst_busy", busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
